// File: rtl/cmul_share_arbiter.sv
// cmul_share_arbiter
// Shares one pipelined complex multiplier among N_REQ requesters (the
// R-inverse sub-sequencers). Requests are granted round-robin, operands are
// registered into the multiplier, and a tag pipe matching MUL_LATENCY routes
// each product back with a one-hot response strobe. A flush pulse stops new
// grants and reports flush_done once every outstanding product is returned.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   req                 per-requester request level
//   opa_flat, opb_flat  per-requester operands, slice i = {imag, real}
//   flush               pulse: stop granting and drain the multiplier
//   gnt                 one-hot pulse: that requester's operands were taken
//   mul_valid, mul_a_*, mul_b_*   registered issue to the multiplier
//   mul_p_r, mul_p_i    multiplier product, MUL_LATENCY cycles after issue
//   rsp_valid, rsp_r, rsp_i       one-hot result strobe and registered result
//   busy                any op in flight or arbiter not idle
//   flush_done          one-cycle pulse when a drain completes
//
// Build option: define CMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no rotating pointer). Undefined: round-robin.
module cmul_share_arbiter #(
  parameter int DATA_WIDTH  = 17,
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*2*DATA_WIDTH-1:0] opa_flat,
  input  logic [N_REQ*2*DATA_WIDTH-1:0] opb_flat,
  input  logic                          flush,
  output logic [N_REQ-1:0]              gnt,
  output logic                          mul_valid,
  output logic [DATA_WIDTH-1:0]         mul_a_r,
  output logic [DATA_WIDTH-1:0]         mul_a_i,
  output logic [DATA_WIDTH-1:0]         mul_b_r,
  output logic [DATA_WIDTH-1:0]         mul_b_i,
  input  logic [DATA_WIDTH-1:0]         mul_p_r,
  input  logic [DATA_WIDTH-1:0]         mul_p_i,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_r,
  output logic [DATA_WIDTH-1:0]         rsp_i,
  output logic                          busy,
  output logic                          flush_done
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OP_W = 2 * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]             state_r, state_nxt_s;
  logic [N_REQ-1:0]       inflight_r;
  logic [N_REQ-1:0]       gnt_r;
  logic                   mul_valid_r;
  logic [ID_W-1:0]        mul_id_r;
  logic [DATA_WIDTH-1:0]  mul_a_re_r, mul_a_im_r, mul_b_re_r, mul_b_im_r;
  logic [MUL_LATENCY-1:0] tag_vld_r;
  logic [ID_W-1:0]        tag_id_r [MUL_LATENCY];
  logic [N_REQ-1:0]       rsp_valid_r;
  logic [DATA_WIDTH-1:0]  rsp_re_r, rsp_im_r;
  logic                   flush_done_r, flush_done_nxt_s;

  logic [ID_W-1:0]        ptr_s;
  logic [N_REQ-1:0]       elig_s;
  logic                   pipe_busy_s;
  logic                   pick_vld_s;
  logic [ID_W-1:0]        pick_id_s;
  logic                   grant_s;
  logic [N_REQ-1:0]       grant_oh_s;
  logic [N_REQ-1:0]       rsp_oh_s;
  logic                   drain_done_s;
  logic [OP_W-1:0]        opa_arr_s [N_REQ];
  logic [OP_W-1:0]        opb_arr_s [N_REQ];
  logic [OP_W-1:0]        sel_a_s, sel_b_s;

`ifdef CMUL_ARB_FIXED_PRIO_EN
  // Pointer pinned at 0: the search below degenerates to lowest-index-first.
  assign ptr_s = {ID_W{1'b0}};
`else
  logic [ID_W-1:0] ptr_r;
  assign ptr_s = ptr_r;
`endif

  // A requester with an op outstanding is masked until the cycle after its rsp.
  assign elig_s      = req & ~inflight_r;
  assign pipe_busy_s = mul_valid_r | (|tag_vld_r);
  assign grant_s     = pick_vld_s && !flush && (state_r == ST_IDLE || state_r == ST_ARB);
  // The last response may be on rsp_valid now; its inflight bit drops next edge.
  assign drain_done_s = !pipe_busy_s && ((inflight_r & ~rsp_valid_r) == {N_REQ{1'b0}});

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      opa_arr_s[i] = opa_flat[i*OP_W +: OP_W];
      opb_arr_s[i] = opb_flat[i*OP_W +: OP_W];
    end
  end

  assign sel_a_s = opa_arr_s[pick_id_s];
  assign sel_b_s = opb_arr_s[pick_id_s];

  // Pick the first eligible requester at or after the pointer, wrapping.
  always_comb begin
    int cand;
    logic [ID_W-1:0] cand_id;
    cand       = 0;
    cand_id    = {ID_W{1'b0}};
    pick_vld_s = 1'b0;
    pick_id_s  = {ID_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand    = (int'(ptr_s) + i) % N_REQ;
      cand_id = ID_W'(cand);
      if (!pick_vld_s && elig_s[cand_id]) begin
        pick_vld_s = 1'b1;
        pick_id_s  = cand_id;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // One-hot forms of the grant and of the tag leaving the pipe.
  always_comb begin
    grant_oh_s = {N_REQ{1'b0}};
    rsp_oh_s   = {N_REQ{1'b0}};
    if (grant_s) begin
      grant_oh_s[pick_id_s] = 1'b1;
    end else begin
      grant_oh_s = {N_REQ{1'b0}};
    end
    if (tag_vld_r[MUL_LATENCY-1]) begin
      rsp_oh_s[tag_id_r[MUL_LATENCY-1]] = 1'b1;
    end else begin
      rsp_oh_s = {N_REQ{1'b0}};
    end
  end

  // Control state transitions and the flush_done pulse.
  always_comb begin
    state_nxt_s      = ST_IDLE;
    flush_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          flush_done_nxt_s = 1'b1;
          state_nxt_s      = ST_IDLE;
        end else if (pick_vld_s) begin
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (flush) begin
          state_nxt_s = ST_DRAIN;
        end else if (elig_s == {N_REQ{1'b0}} && !pipe_busy_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          flush_done_nxt_s = 1'b1;
          state_nxt_s      = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // All registered state: control, issue, tag pipe, response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      inflight_r   <= {N_REQ{1'b0}};
      gnt_r        <= {N_REQ{1'b0}};
      mul_valid_r  <= 1'b0;
      mul_id_r     <= {ID_W{1'b0}};
      mul_a_re_r   <= {DATA_WIDTH{1'b0}};
      mul_a_im_r   <= {DATA_WIDTH{1'b0}};
      mul_b_re_r   <= {DATA_WIDTH{1'b0}};
      mul_b_im_r   <= {DATA_WIDTH{1'b0}};
      tag_vld_r    <= {MUL_LATENCY{1'b0}};
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_id_r[i] <= {ID_W{1'b0}};
      end
      rsp_valid_r  <= {N_REQ{1'b0}};
      rsp_re_r     <= {DATA_WIDTH{1'b0}};
      rsp_im_r     <= {DATA_WIDTH{1'b0}};
      flush_done_r <= 1'b0;
`ifndef CMUL_ARB_FIXED_PRIO_EN
      ptr_r        <= {ID_W{1'b0}};
`endif
    end else begin
      state_r      <= state_nxt_s;
      flush_done_r <= flush_done_nxt_s;
      inflight_r   <= (inflight_r & ~rsp_valid_r) | grant_oh_s;
      gnt_r        <= grant_oh_s;
      mul_valid_r  <= grant_s;
      if (grant_s) begin
        mul_id_r   <= pick_id_s;
        mul_a_re_r <= sel_a_s[DATA_WIDTH-1:0];
        mul_a_im_r <= sel_a_s[OP_W-1:DATA_WIDTH];
        mul_b_re_r <= sel_b_s[DATA_WIDTH-1:0];
        mul_b_im_r <= sel_b_s[OP_W-1:DATA_WIDTH];
`ifndef CMUL_ARB_FIXED_PRIO_EN
        ptr_r      <= ID_W'((int'(pick_id_s) + 1) % N_REQ);
`endif
      end
      // Stage 0 follows the issue register, so the last stage lines up with
      // the cycle in which the multiplier presents that op's product.
      tag_vld_r[0] <= mul_valid_r;
      tag_id_r[0]  <= mul_id_r;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
      rsp_valid_r <= rsp_oh_s;
      if (tag_vld_r[MUL_LATENCY-1]) begin
        rsp_re_r <= mul_p_r;
        rsp_im_r <= mul_p_i;
      end
    end
  end

  assign gnt        = gnt_r;
  assign mul_valid  = mul_valid_r;
  assign mul_a_r    = mul_a_re_r;
  assign mul_a_i    = mul_a_im_r;
  assign mul_b_r    = mul_b_re_r;
  assign mul_b_i    = mul_b_im_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_r      = rsp_re_r;
  assign rsp_i      = rsp_im_r;
  assign flush_done = flush_done_r;
  assign busy       = (state_r != ST_IDLE) | (|inflight_r) | pipe_busy_s;

endmodule

// File: tb/tb_cmul_share_arbiter.sv
// Bench for cmul_share_arbiter: a Q5.12 complex multiplier model feeds
// mul_p_*, a per-cycle reference model checks every output, and directed
// sequences cover reset, single requests, back-to-back issue, flush and
// reset while ops are in flight, followed by a randomized requester phase.
module tb_cmul_share_arbiter;
  localparam int DW  = 17;
  localparam int NR  = 4;
  localparam int ML  = 3;
  localparam int OPW = 2 * DW;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NR-1:0]   req;
  logic [NR*OPW-1:0] opa_flat, opb_flat;
  logic            flush;
  logic [NR-1:0]   gnt;
  logic            mul_valid;
  logic [DW-1:0]   mul_a_r, mul_a_i, mul_b_r, mul_b_i;
  logic [DW-1:0]   mul_p_r, mul_p_i;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_r, rsp_i;
  logic            busy, flush_done;

  cmul_share_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .MUL_LATENCY(ML)) dut (
    .CLK(CLK), .RST(RST), .req(req), .opa_flat(opa_flat), .opb_flat(opb_flat),
    .flush(flush), .gnt(gnt), .mul_valid(mul_valid),
    .mul_a_r(mul_a_r), .mul_a_i(mul_a_i), .mul_b_r(mul_b_r), .mul_b_i(mul_b_i),
    .mul_p_r(mul_p_r), .mul_p_i(mul_p_i), .rsp_valid(rsp_valid),
    .rsp_r(rsp_r), .rsp_i(rsp_i), .busy(busy), .flush_done(flush_done)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Q5.12 complex product, truncated back to DW bits.
  function automatic logic [OPW-1:0] cmul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic signed [DW-1:0] ar, ai, br, bi;
    longint pr, pi;
    ar = a[DW-1:0]; ai = a[OPW-1:DW];
    br = b[DW-1:0]; bi = b[OPW-1:DW];
    pr = (longint'(ar) * longint'(br) - longint'(ai) * longint'(bi)) >>> 12;
    pi = (longint'(ar) * longint'(bi) + longint'(ai) * longint'(br)) >>> 12;
    return {pi[DW-1:0], pr[DW-1:0]};
  endfunction

  // Multiplier model: product of the registered operands, ML cycles later.
  logic [OPW-1:0] mp_pipe [ML];
  always @(posedge CLK) begin
    mp_pipe[0] <= cmul({mul_a_i, mul_a_r}, {mul_b_i, mul_b_r});
    for (int i = 1; i < ML; i++) mp_pipe[i] <= mp_pipe[i-1];
  end
  assign mul_p_r = mp_pipe[ML-1][DW-1:0];
  assign mul_p_i = mp_pipe[ML-1][OPW-1:DW];

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 arbitrating, 2 draining. Each granted op carries a
  // countdown to its response edge (ML+1 edges after the grant edge).
  int             m_mode, m_ptr;
  logic [NR-1:0]  m_infl, m_rsp_prev;
  int             m_due [NR];
  logic [OPW-1:0] m_prod [NR];
  logic [NR-1:0]  e_gnt, e_rv;
  logic           e_mv, e_fd, e_busy;
  logic [DW-1:0]  e_mar, e_mai, e_mbr, e_mbi, e_rspr, e_rspi;

  always @(posedge CLK) begin : model
    logic [NR-1:0] elig, new_rv;
    int k, j;
    bit pipe_busy, any_due;
    if (RST) begin
      m_mode = 0; m_ptr = 0; m_infl = '0; m_rsp_prev = '0;
      for (int i = 0; i < NR; i++) m_due[i] = 0;
      e_gnt = '0; e_rv = '0; e_mv = 1'b0; e_fd = 1'b0; e_busy = 1'b0;
      e_mar = '0; e_mai = '0; e_mbr = '0; e_mbi = '0; e_rspr = '0; e_rspi = '0;
    end else begin
      elig = req & ~m_infl;
      pipe_busy = 1'b0;
      for (int i = 0; i < NR; i++) if (m_due[i] > 0) pipe_busy = 1'b1;
      k = -1;
      if ((m_mode == 0 || m_mode == 1) && !flush) begin
        for (int i = 0; i < NR; i++) begin
          j = (m_ptr + i) % NR;
          if (k < 0 && elig[j]) k = j;
        end
      end
      e_fd = 1'b0;
      if (m_mode == 0) begin
        if (flush) e_fd = 1'b1;
        else if (k >= 0) m_mode = 1;
      end else if (m_mode == 1) begin
        if (flush) m_mode = 2;
        else if (elig == '0 && !pipe_busy) m_mode = 0;
      end else begin
        if (!pipe_busy && (m_infl & ~m_rsp_prev) == '0) begin
          e_fd = 1'b1; m_mode = 0;
        end
      end
      new_rv = '0;
      for (int i = 0; i < NR; i++) begin
        if (m_due[i] == 1) begin
          new_rv[i] = 1'b1; m_due[i] = 0;
          e_rspr = m_prod[i][DW-1:0]; e_rspi = m_prod[i][OPW-1:DW];
        end else if (m_due[i] > 0) m_due[i]--;
      end
      e_gnt = '0;
      e_mv = (k >= 0);
      if (k >= 0) begin
        e_gnt[k] = 1'b1;
        m_due[k] = ML + 1;
        m_prod[k] = cmul(opa_flat[k*OPW +: OPW], opb_flat[k*OPW +: OPW]);
        e_mar = opa_flat[k*OPW +: DW]; e_mai = opa_flat[k*OPW+DW +: DW];
        e_mbr = opb_flat[k*OPW +: DW]; e_mbi = opb_flat[k*OPW+DW +: DW];
`ifndef CMUL_ARB_FIXED_PRIO_EN
        m_ptr = (k + 1) % NR;
`endif
      end
      m_infl = (m_infl & ~m_rsp_prev) | e_gnt;
      m_rsp_prev = new_rv;
      e_rv = new_rv;
      any_due = 1'b0;
      for (int i = 0; i < NR; i++) if (m_due[i] > 0) any_due = 1'b1;
      e_busy = (m_mode != 0) || (m_infl != '0) || any_due;
    end
    #1;
    chk("m_gnt", gnt, e_gnt);
    chk("m_mul_valid", mul_valid, e_mv);
    chk("m_rsp_valid", rsp_valid, e_rv);
    chk("m_flush_done", flush_done, e_fd);
    chk("m_busy", busy, e_busy);
    chk("m_rsp_r", rsp_r, e_rspr);
    chk("m_rsp_i", rsp_i, e_rspi);
    chk("m_mul_a", {mul_a_i, mul_a_r}, {e_mai, e_mar});
    chk("m_mul_b", {mul_b_i, mul_b_r}, {e_mbi, e_mbr});
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    int            id;
    logic [OPW-1:0] a, b;
    logic [DW-1:0] er, ei;
  } vec_t;
  vec_t vecs [4];

  task automatic set_ops(input int id, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    opa_flat[id*OPW +: OPW] = a;
    opb_flat[id*OPW +: OPW] = b;
  endtask

  function automatic logic [OPW-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[OPW-1:0];
  endfunction

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 60) begin
      @(negedge CLK);
      t++;
    end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    logic [NR-1:0] oh, g1, g2;
    logic [NR-1:0] gh [30];
    logic          mvh [30];
    logic [NR-1:0] rvh [30];
    int gq [$];
    int gcount, rcount, fcount, last_r, fd_t, rsp_seen, run;
    logic busy_after;

    vecs[0] = '{2, {17'h00800, 17'h01000}, {17'h00000, 17'h02000}, 17'h02000, 17'h01000};
    vecs[1] = '{0, {17'h00000, 17'h01000}, {17'h00800, 17'h00800}, 17'h00800, 17'h00800};
    vecs[2] = '{3, {17'h01000, 17'h02000}, {17'h01000, 17'h01000}, 17'h01000, 17'h03000};
    vecs[3] = '{1, {17'h00000, 17'h1F000}, {17'h00400, 17'h01800}, 17'h1E800, 17'h1FC00};

    RST = 1'b1; req = 4'b1111; flush = 1'b0; opa_flat = '0; opb_flat = '0;
    // Reset holds everything quiet even with all requests asserted.
    repeat (3) begin
      @(negedge CLK);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_mul_valid", mul_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 4'b0000);
    end
    RST = 1'b0; req = 4'b0000;
    @(negedge CLK);

    // Single requests from the vector table.
    for (int v = 0; v < 4; v++) begin
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      oh = 4'b0001 << vecs[v].id;
      req = oh;
      @(negedge CLK);
      chk("tbl_gnt", gnt, oh);
      req = 4'b0000;
      for (int t = 1; t <= ML + 1; t++) @(negedge CLK);
      chk("tbl_rsp_valid", rsp_valid, oh);
      chk("tbl_rsp_r", rsp_r, vecs[v].er);
      chk("tbl_rsp_i", rsp_i, vecs[v].ei);
      @(negedge CLK);
      chk("tbl_rsp_clear", rsp_valid, 4'b0000);
    end

    // Back-to-back: pointer back to 0, all four request at once and hold.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < NR; i++) set_ops(i, rnd_op(), rnd_op());
    req = 4'b1111;
    for (int t = 0; t < 30; t++) begin
      @(negedge CLK);
      gh[t] = gnt; mvh[t] = mul_valid; rvh[t] = rsp_valid;
    end
    req = 4'b0000;
    for (int t = 0; t < 30; t++)
      for (int i = 0; i < NR; i++) if (gh[t][i]) gq.push_back(i);
    if (gq.size() < 6) begin
      n_cmp++; n_err++;
      $display("FAIL b2b_grant_count: got %0d grants, expected at least 6", gq.size());
    end else begin
      for (int j = 0; j < 6; j++) chk("b2b_grant_order", gq[j], j % NR);
    end
    run = 0;
    while (run < 30 && mvh[run] === 1'b1) run++;
    chk("b2b_mul_valid_run", run, 4);
    for (int j = 0; j < 4; j++) chk("b2b_rsp_seq", rvh[ML + 1 + j], 4'b0001 << j);
    wait_idle("b2b_idle");

    // Flush with two ops in flight; requester 2 asks during the drain.
    req = 4'b0011;
    @(negedge CLK); g1 = gnt;
    @(negedge CLK); g2 = gnt;
    chk("fl_two_grants", g1 | g2, 4'b0011);
    req = 4'b0000;
    @(negedge CLK);
    flush = 1'b1; req = 4'b0100;
    @(negedge CLK);
    flush = 1'b0;
    gcount = 0; rcount = 0; fcount = 0; last_r = -10; fd_t = -10; busy_after = 1'bx;
    for (int t = 0; t < 20; t++) begin
      if (gnt != 4'b0000 && fcount == 0) gcount++;
      if (rsp_valid != 4'b0000) begin rcount++; last_r = t; end
      if (t == fd_t + 1) busy_after = busy;
      if (flush_done) begin fcount++; fd_t = t; req = 4'b0000; end
      @(negedge CLK);
    end
    chk("fl_no_grant", gcount, 0);
    chk("fl_rsp_count", rcount, 2);
    chk("fl_done_count", fcount, 1);
    chk("fl_done_timing", fd_t, last_r + 1);
    chk("fl_busy_after", busy_after, 1'b0);
    wait_idle("fl_idle");

    // Reset one cycle after granting requester 1.
    set_ops(1, rnd_op(), rnd_op());
    req = 4'b0010;
    @(negedge CLK);
    chk("rmf_gnt", gnt, 4'b0010);
    req = 4'b0000; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    rsp_seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (rsp_valid != 4'b0000) rsp_seen++;
    end
    chk("rmf_no_rsp", rsp_seen, 0);
    set_ops(0, rnd_op(), rnd_op());
    set_ops(2, rnd_op(), rnd_op());
    req = 4'b0101;
    @(negedge CLK);
    chk("rmf_ptr_zero", gnt, 4'b0001);
    req = 4'b0000;
    wait_idle("rmf_idle");

    // Random requesters, flushes and occasional resets.
    for (int c = 0; c < 800; c++) begin
      @(negedge CLK);
      flush = ($urandom_range(0, 49) == 0);
      RST   = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (gnt[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            else set_ops(i, rnd_op(), rnd_op());
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_ops(i, rnd_op(), rnd_op());
          req[i] = 1'b1;
        end
      end
    end
    @(negedge CLK);
    req = 4'b0000; flush = 1'b0; RST = 1'b0;
    wait_idle("rnd_idle");

    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cmul_share_arbiter.md
Name: cmul_share_arbiter

Overview:
Shares one pipelined fixed-point complex multiplier among N_REQ requesters. The requesters are the R-inverse sub-sequencers that compute Rinv13, Rinv24 and Rinv14 partial products. The arbiter uses round-robin arbitration, registers operands into the multiplier and tracks requester IDs through a tag pipeline matching the multiplier latency. Each result is routed back with a one-hot response strobe. A flush handshake lets the top-level R-inverse controller drain the multiplier before declaring R_inverse_done.

Parameters:
DATA_WIDTH, 17, operand/result width (INT_LENGTH 5 + FRAC_LENGTH 12, two's complement)
N_REQ, 4, number of requesters (2..8)
MUL_LATENCY, 3, cycles from mul_valid to valid mul_p_r/mul_p_i (1..8)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
req  in  N_REQ  request per requester, level
opa_flat  in  N_REQ*2*DATA_WIDTH  operand A per requester; slice i = {imag, real}, real in low half
opb_flat  in  N_REQ*2*DATA_WIDTH  operand B, same packing
flush  in  1  single-cycle pulse: stop granting, drain pipeline
gnt  out  N_REQ  one-hot, one-cycle pulse: operands of that requester captured
mul_valid  out  1  issue strobe to multiplier
mul_a_r, mul_a_i, mul_b_r, mul_b_i  out  DATA_WIDTH each  registered operands to multiplier
mul_p_r, mul_p_i  in  DATA_WIDTH each  multiplier product, valid MUL_LATENCY cycles after mul_valid
rsp_valid  out  N_REQ  one-hot result strobe
rsp_r, rsp_i  out  DATA_WIDTH each  result (registered copy of mul_p_*)
busy  out  1  high when any op is in flight or state is not IDLE
flush_done  out  1  one-cycle pulse when drain completes

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE; gnt, mul_valid, rsp_valid, flush_done = 0; mul_*, rsp_* = 0; RR pointer=0; in-flight mask=0; tag pipe cleared. Reset mid-operation discards in-flight ops and emits no rsp.
- Eligible requests: elig = req & ~inflight. inflight[i] is set on gnt[i] and cleared on rsp_valid[i]. Each requester has at most one op outstanding.
- States:
  - IDLE: goes to ARB when elig != 0.
  - ARB: arbitrates every cycle; goes to IDLE when elig == 0 and the pipe is empty; goes to DRAIN on flush.
  - DRAIN: no grants; when the tag pipe and inflight are both empty, pulse flush_done for one cycle and go to IDLE.
  - flush in IDLE: pulse flush_done on the next cycle, stay IDLE.
- Arbitration (ARB): combinational pick of the first elig bit at or after the RR pointer, wrapping N_REQ-1 to 0. On the next edge the arbiter registers gnt[k]=1 and mul_valid=1, latches operands of k into mul_*, and sets pointer=(k+1) mod N_REQ. One issue per cycle; back-to-back issue allowed. Latency req to gnt = 1 cycle.
- Requester protocol: hold operands stable while req is high until gnt is seen. A requester that still has req high when its rsp arrives is treated as issuing a new request; it becomes eligible the cycle after rsp_valid.
- Tag pipe: MUL_LATENCY-deep shift register of {valid, id}, loaded with mul_valid/k. At its output the arbiter registers rsp_r/rsp_i from mul_p_* and sets rsp_valid[id]=1. Total latency gnt to rsp_valid = MUL_LATENCY+1 cycles.
- Flush and grant in the same cycle: flush has priority; no grant is issued that cycle.
- Arithmetic: pure routing, no width change. Overflow and rounding are the multiplier's responsibility.
- Illegal state encoding: next state is IDLE.

Optional Feature:
CMUL_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; the RR pointer is removed and held at 0. Used when Rinv14 partials must beat Rinv24 partials.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: hold RST=1 with req=4'b1111 -> gnt=0, mul_valid=0, busy=0, rsp_valid=0 for all cycles under reset.
- Single request: req=4'b0100 with opa=(1.0, 0.5), opb=(2.0, 0) (Q5.12: 0x1000, 0x0800 / 0x2000, 0) -> gnt=4'b0100 one cycle later; rsp_valid=4'b0100 after MUL_LATENCY+1=4 more cycles; rsp=(0x2000, 0x1000) from the reference multiplier model.
- Round-robin fairness: all req held high, each requester drops req 1 cycle after its rsp then re-requests -> grant order 0,1,2,3,0,1; no requester is granted twice while another is eligible.
- Back-to-back issue: req=4'b1111 asserted at once -> mul_valid high 4 consecutive cycles; rsp_valid one-hot sequence 0001, 0010, 0100, 1000 on 4 consecutive cycles.
- Flush with ops in flight: flush 2 cycles after 2 grants -> no further gnt; flush_done pulses exactly 1 cycle after the last rsp_valid; then busy=0 and state IDLE.
- Reset mid-flight: RST high 1 cycle after a grant -> no rsp_valid ever appears for that op; the next request is served with the RR pointer at 0.
